// File: rtl/im2col_pkg.sv
// Shared constants and types for the im2col row packer (pixel, row, slot, counter types).
package im2col_pkg;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 10;
  localparam int ROW_LEN  = 25;
  localparam int VEC_ROWS = 4;
  localparam int COL_W    = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int CNT_W    = (VEC_ROWS > 1) ? $clog2(VEC_ROWS) : 1;

  typedef logic [DATA_W-1:0]      pixel_t;
  typedef pixel_t [ROW_LEN-1:0]   row_t;
  typedef logic                   slot_idx_t;
  typedef logic [COL_W-1:0]       col_idx_t;
  typedef logic [CNT_W-1:0]       row_cnt_t;

  localparam col_idx_t LAST_COL = col_idx_t'(ROW_LEN - 1);
  localparam row_cnt_t LAST_ROW = row_cnt_t'(VEC_ROWS - 1);
endpackage

// File: rtl/im2col_row_slot.sv
// One ping-pong row buffer: column write port plus busy/full flags.
// Optional ROW_NZ_MASK_EN adds a per-element nonzero mask captured at write time.
module im2col_row_slot
  import im2col_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     alloc,
  input  logic     drain,
  input  logic     wr_en,
  input  col_idx_t wr_col,
  input  pixel_t   wr_data,
  input  logic     wr_last,
  output logic     busy,
  output logic     full,
  output row_t     data
`ifdef ROW_NZ_MASK_EN
  ,
  output logic [ROW_LEN-1:0] nz_mask
`endif
);

  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= 1'b0;
      full <= 1'b0;
    end else begin
      if (alloc)
        busy <= 1'b1;
      if (wr_en && wr_last)
        full <= 1'b1;
      // a drained slot is free again; drain never coincides with alloc/last on the same slot
      if (drain) begin
        busy <= 1'b0;
        full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      data <= '0;
    else if (wr_en)
      data[wr_col] <= wr_data;
  end

`ifdef ROW_NZ_MASK_EN
  always_ff @(posedge clock) begin
    if (reset)
      nz_mask <= '0;
    else if (wr_en)
      nz_mask[wr_col] <= (wr_data != '0);
  end
`endif

endmodule

// File: rtl/im2col_row_packer.sv
// Packs ifmap SRAM reads into ROW_LEN-element im2col rows through a ping-pong buffer.
// Define ROW_NZ_MASK_EN to add the row_nz_mask output.
module im2col_row_packer
  import im2col_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      addr_valid,
  input  logic [ADDR_W-1:0]         addr_in,
  output logic                      addr_ready,
  output logic                      sram_re,
  output logic [ADDR_W-1:0]         sram_addr,
  input  logic [DATA_W-1:0]         sram_rdata,
  output logic                      row_valid,
  input  logic                      row_ready,
  output logic [ROW_LEN*DATA_W-1:0] row_data,
  output logic                      row_last,
  output logic                      stream_done
`ifdef ROW_NZ_MASK_EN
  ,
  output logic [ROW_LEN-1:0]        row_nz_mask
`endif
);

  logic      flush;
  logic      accept;
  logic      row_fire;
  slot_idx_t iss_ptr;
  slot_idx_t rd_ptr;
  col_idx_t  iss_col;
  row_cnt_t  row_cnt;

  logic      wb_vld_p1;
  slot_idx_t wb_slot_p1;
  col_idx_t  wb_col_p1;
  logic      wb_last_p1;

  logic      busy      [2];
  logic      full      [2];
  row_t      slot_data [2];
`ifdef ROW_NZ_MASK_EN
  logic [ROW_LEN-1:0] slot_mask [2];
`endif

  assign flush      = reset | clear;
  // busy is registered, so a slot released this cycle is reissued no earlier than next cycle
  assign addr_ready = ~flush & ((iss_col != '0) | ~busy[iss_ptr]);
  assign accept     = addr_valid & addr_ready;
  assign sram_re    = accept;
  assign sram_addr  = addr_in;

  assign row_valid   = full[rd_ptr];
  assign row_data    = slot_data[rd_ptr];
  assign row_last    = (row_cnt == LAST_ROW);
  assign row_fire    = row_valid & row_ready & ~flush;
  assign stream_done = row_fire & row_last;
`ifdef ROW_NZ_MASK_EN
  assign row_nz_mask = slot_mask[rd_ptr];
`endif

  // p0: issue side, address accepted and SRAM read launched
  always_ff @(posedge clock) begin
    if (flush) begin
      iss_ptr <= 1'b0;
      iss_col <= '0;
    end else if (accept) begin
      if (iss_col == LAST_COL) begin
        iss_col <= '0;
        iss_ptr <= ~iss_ptr;
      end else begin
        iss_col <= iss_col + 1'b1;
      end
    end
  end

  // p1: write-back, SRAM data lands in its slot/column
  always_ff @(posedge clock) begin
    if (flush) begin
      wb_vld_p1  <= 1'b0;
      wb_slot_p1 <= 1'b0;
      wb_col_p1  <= '0;
      wb_last_p1 <= 1'b0;
    end else begin
      wb_vld_p1  <= accept;
      wb_slot_p1 <= iss_ptr;
      wb_col_p1  <= iss_col;
      wb_last_p1 <= (iss_col == LAST_COL);
    end
  end

  always_ff @(posedge clock) begin
    if (flush) begin
      rd_ptr  <= 1'b0;
      row_cnt <= '0;
    end else if (row_fire) begin
      rd_ptr  <= ~rd_ptr;
      row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
    end
  end

  for (genvar s = 0; s < 2; s++) begin : g_slot
    im2col_row_slot u_slot (
      .clock   (clock),
      .reset   (flush),
      .alloc   (accept && (iss_col == '0) && (iss_ptr == slot_idx_t'(s))),
      .drain   (row_fire && (rd_ptr == slot_idx_t'(s))),
      .wr_en   (wb_vld_p1 && (wb_slot_p1 == slot_idx_t'(s))),
      .wr_col  (wb_col_p1),
      .wr_data (sram_rdata),
      .wr_last (wb_last_p1),
      .busy    (busy[s]),
      .full    (full[s]),
      .data    (slot_data[s])
`ifdef ROW_NZ_MASK_EN
      ,
      .nz_mask (slot_mask[s])
`endif
    );
  end

endmodule

// File: tb/tb_im2col_row_packer.sv
// Scoreboard bench for im2col_row_packer: SRAM model, expected rows queued at address accept.
`timescale 1ns/1ps
module tb_im2col_row_packer;
  import im2col_pkg::*;

  logic                      clock = 1'b0;
  logic                      reset, clear, addr_valid, addr_ready, sram_re;
  logic                      row_valid, row_ready, row_last, stream_done;
  logic [ADDR_W-1:0]         addr_in, sram_addr;
  logic [DATA_W-1:0]         sram_rdata;
  logic [ROW_LEN*DATA_W-1:0] row_data;
`ifdef ROW_NZ_MASK_EN
  logic [ROW_LEN-1:0]        row_nz_mask;
  logic [ROW_LEN-1:0]        exp_mask;
`endif

  int   n_vec = 0, n_err = 0, cyc = 0;
  int   rows_seen = 0, done_cnt = 0, last_acc_cyc = 0, first_vld_cyc = -1;
  int   cur_n = 0, exp_cnt = 0;
  bit   zero_even = 1'b0;
  row_t sb_rows[$];
  bit   sb_last[$];
  row_t cur_row, exp_r;
  bit   exp_l;

  im2col_row_packer dut (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .addr_valid  (addr_valid),
    .addr_in     (addr_in),
    .addr_ready  (addr_ready),
    .sram_re     (sram_re),
    .sram_addr   (sram_addr),
    .sram_rdata  (sram_rdata),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .row_data    (row_data),
    .row_last    (row_last),
    .stream_done (stream_done)
`ifdef ROW_NZ_MASK_EN
    ,
    .row_nz_mask (row_nz_mask)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic pixel_t sram_val(input logic [ADDR_W-1:0] a);
    if (zero_even && !a[0])
      return '0;
    return a[DATA_W-1:0];
  endfunction

  always @(posedge clock)
    if (sram_re)
      sram_rdata <= sram_val(sram_addr);

  // Monitor: expected rows are built from accepted addresses, checked on row handshake.
  always @(negedge clock) begin
    if (reset || clear) begin
      cur_n = 0;
      exp_cnt = 0;
      first_vld_cyc = -1;
      sb_rows.delete();
      sb_last.delete();
    end else begin
      if (addr_valid && addr_ready) begin
        n_vec++;
        if (sram_re !== 1'b1 || sram_addr !== addr_in) begin
          n_err++;
          $display("FAIL sram_issue: re=%b addr=%0d, required re=1 addr=%0d", sram_re, sram_addr, addr_in);
        end
        cur_row[cur_n] = sram_val(addr_in);
        last_acc_cyc = cyc;
        cur_n++;
        if (cur_n == ROW_LEN) begin
          sb_rows.push_back(cur_row);
          sb_last.push_back(exp_cnt == VEC_ROWS - 1);
          exp_cnt = (exp_cnt + 1) % VEC_ROWS;
          cur_n = 0;
        end
      end else if (sram_re !== 1'b0) begin
        n_vec++;
        n_err++;
        $display("FAIL sram_idle: re=%b without accept, required 0", sram_re);
      end
      if (row_valid === 1'b1 && first_vld_cyc < 0)
        first_vld_cyc = cyc;
      if (row_valid && row_ready) begin
        n_vec++;
        if (sb_rows.size() == 0) begin
          n_err++;
          $display("FAIL row_unexpected: row_valid=1 with no expected row queued");
        end else begin
          exp_r = sb_rows.pop_front();
          exp_l = sb_last.pop_front();
          if (row_data !== exp_r || row_last !== exp_l || stream_done !== exp_l) begin
            n_err++;
            $display("FAIL row_data: got data=%h last=%b done=%b, required data=%h last=%b done=%b",
                     row_data, row_last, stream_done, exp_r, exp_l, exp_l);
          end
`ifdef ROW_NZ_MASK_EN
          for (int k = 0; k < ROW_LEN; k++)
            exp_mask[k] = (exp_r[k] != '0);
          n_vec++;
          if (row_nz_mask !== exp_mask) begin
            n_err++;
            $display("FAIL row_nz_mask: got %h, required %h", row_nz_mask, exp_mask);
          end
`endif
        end
        rows_seen++;
        if (stream_done === 1'b1)
          done_cnt++;
      end else if (stream_done !== 1'b0) begin
        n_vec++;
        n_err++;
        $display("FAIL stream_done_idle: got %b without handshake, required 0", stream_done);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear = 1'b0;
    addr_valid = 1'b0;
    addr_in = '0;
    row_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    rows_seen = 0;
    done_cnt = 0;
  endtask

  task automatic send_addr(input logic [ADDR_W-1:0] a, input int gap);
    int budget = 500;
    addr_valid = 1'b1;
    addr_in = a;
    @(negedge clock);
    while (!addr_ready && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (!addr_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: addr %0d not accepted, addr_ready=%b required 1", a, addr_ready);
    end
    tick();
    if (gap > 0) begin
      addr_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic wait_rows(input int n, input string name);
    int budget = 400;
    while (rows_seen < n && budget > 0) begin
      tick();
      budget--;
    end
    repeat (4) tick();
    n_vec++;
    if (rows_seen != n || sb_rows.size() != 0) begin
      n_err++;
      $display("FAIL %s: rows=%0d pending=%0d, required rows=%0d pending=0", name, rows_seen, sb_rows.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear = 1'b0;
    addr_valid = 1'b1;
    addr_in = 10'd5;
    row_ready = 1'b1;
    tick();
    tick();
    @(negedge clock);
    n_vec++;
    if (addr_ready !== 1'b0 || sram_re !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready: addr_ready=%b sram_re=%b, required 0 0", addr_ready, sram_re);
    end
    tick();
    reset = 1'b0;
    addr_valid = 1'b0;
    @(negedge clock);
    n_vec++;
    if (row_valid !== 1'b0 || row_last !== 1'b0 || stream_done !== 1'b0 || row_data !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%b last=%b done=%b data=%h, required all 0",
               row_valid, row_last, stream_done, row_data);
    end
    n_vec++;
    if (addr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: addr_ready=%b, required 1", addr_ready);
    end
    tick();
  endtask

  task automatic test_single_row();
    int budget = 50;
    do_reset();
    row_ready = 1'b1;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        send_addr(10'(28 * r + c), 0);
    addr_valid = 1'b0;
    while (first_vld_cyc < 0 && budget > 0) begin
      tick();
      budget--;
    end
    n_vec++;
    if (first_vld_cyc - last_acc_cyc != 2) begin
      n_err++;
      $display("FAIL row_latency: row_valid after %0d cycles, required 2", first_vld_cyc - last_acc_cyc);
    end
    wait_rows(1, "single_row_count");
  endtask

  task automatic test_full_vector();
    do_reset();
    row_ready = 1'b1;
    for (int i = 0; i < 100; i++)
      send_addr(10'(400 + i), 0);
    addr_valid = 1'b0;
    wait_rows(4, "vector_row_count");
    n_vec++;
    if (done_cnt != 1) begin
      n_err++;
      $display("FAIL vector_done_count: stream_done pulses=%0d, required 1", done_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [ROW_LEN*DATA_W-1:0] snap;
    do_reset();
    row_ready = 1'b0;
    for (int i = 0; i < 50; i++)
      send_addr(10'(3 * i), 0);
    addr_valid = 1'b1;
    addr_in = 10'd700;
    @(negedge clock);
    snap = row_data;
    n_vec++;
    if (addr_ready !== 1'b0 || row_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_stall: addr_ready=%b row_valid=%b, required 0 1", addr_ready, row_valid);
    end
    repeat (4) begin
      tick();
      @(negedge clock);
      n_vec++;
      if (row_data !== snap || addr_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold: data=%h ready=%b, required data=%h ready=0", row_data, addr_ready, snap);
      end
    end
    tick();
    row_ready = 1'b1;
    @(negedge clock);
    n_vec++;
    if (addr_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release_same_cycle: addr_ready=%b, required 0", addr_ready);
    end
    tick();
    @(negedge clock);
    n_vec++;
    if (addr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_resume: addr_ready=%b, required 1", addr_ready);
    end
    tick();
    for (int i = 1; i < 25; i++)
      send_addr(10'(700 + i), 0);
    addr_valid = 1'b0;
    wait_rows(3, "bp_row_count");
  endtask

  task automatic test_gapped();
    do_reset();
    row_ready = 1'b1;
    for (int i = 0; i < 50; i++)
      send_addr(10'(5 * i + 1), 1);
    addr_valid = 1'b0;
    wait_rows(2, "gapped_row_count");
  endtask

  task automatic test_clear();
    do_reset();
    row_ready = 1'b1;
    for (int i = 0; i < 12; i++)
      send_addr(10'(i + 1), 0);
    addr_valid = 1'b0;
    clear = 1'b1;
    @(negedge clock);
    n_vec++;
    if (addr_ready !== 1'b0) begin
      n_err++;
      $display("FAIL clear_ready: addr_ready=%b during clear, required 0", addr_ready);
    end
    tick();
    clear = 1'b0;
    repeat (3) begin
      @(negedge clock);
      n_vec++;
      if (row_valid !== 1'b0 || row_data !== '0 || addr_ready !== 1'b1) begin
        n_err++;
        $display("FAIL clear_state: valid=%b data=%h ready=%b, required 0 0 1", row_valid, row_data, addr_ready);
      end
      tick();
    end
    for (int i = 0; i < 25; i++)
      send_addr(10'(500 + 2 * i), 0);
    addr_valid = 1'b0;
    wait_rows(1, "clear_row_count");
  endtask

`ifdef ROW_NZ_MASK_EN
  task automatic test_nz_mask();
    do_reset();
    zero_even = 1'b1;
    row_ready = 1'b1;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        send_addr(10'(28 * r + c), 0);
    addr_valid = 1'b0;
    wait_rows(1, "nz_row_count");
    zero_even = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    addr_valid = 1'b0;
    addr_in = '0;
    row_ready = 1'b0;
    test_reset();
    test_single_row();
    test_full_vector();
    test_backpressure();
    test_gapped();
    test_clear();
`ifdef ROW_NZ_MASK_EN
    test_nz_mask();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
